imem_responder: RTL

Memory-side responder for the instruction-fetch bus that the icache drives. It accepts BUS_LOAD/BUS_STORE commands, answers in the same cycle with a tag (or 0 to reject), and returns 64-bit load data with that tag after a fixed latency. It is synthesizable memory behind top_r10k's `Imem2proc_*` and `proc2Imem_*` ports.

---
 rtl/imem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts tagged LOAD/STORE commands and returns load data after a
// fixed latency. Define IMEM_LFSR_STALL_EN to add LFSR-driven pseudo-random command rejection.
module imem_responder #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MEM_LINES       = 1024,
    parameter int unsigned LATENCY         = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2Imem_command,
    input  logic [XLEN-1:0] proc2Imem_addr,
    input  logic [63:0]     proc2Imem_data,
    output logic [3:0]      Imem2proc_response,
    output logic [63:0]     Imem2proc_data,
    output logic [3:0]      Imem2proc_tag
);

    localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CD_W  = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [3:0]      tag;
        logic [63:0]     data;
        logic [CD_W-1:0] cd;
    } entry_t;

    logic [63:0]      mem [MEM_LINES];
    entry_t           fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [3:0]       count_q, count_d;
    logic [3:0]       next_tag_q;
    logic [3:0]       tag_q;
    logic [63:0]      data_q;

    logic             is_load, is_store, in_range, stall_ok, accept;
    logic             push, pop, bypass;
    logic [IDX_W-1:0] line_idx;
    logic [63:0]      rd_data;

`ifdef IMEM_LFSR_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11 in right-shift form
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign stall_ok = (lfsr_q[1:0] != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end
`else
    assign stall_ok = 1'b1;
`endif

    assign is_load  = (proc2Imem_command == 2'd1);
    assign is_store = (proc2Imem_command == 2'd2);
    assign in_range = ((proc2Imem_addr >> 3) < XLEN'(MEM_LINES));
    assign line_idx = proc2Imem_addr[3 +: IDX_W];
    assign rd_data  = mem[line_idx];

    always_comb begin
        accept = 1'b0;
        if (!reset && in_range && stall_ok) begin
            accept = is_store || (is_load && (count_q < 4'(MAX_OUTSTANDING)));
        end
        Imem2proc_response = accept ? next_tag_q : 4'd0;
    end

    // LATENCY == 1 skips the FIFO: the output register is loaded at the accepting edge.
    assign push   = accept && is_load && (LATENCY > 1);
    assign bypass = accept && is_load && (LATENCY == 1);
    // All entries age together, so only the head can ever be due.
    assign pop    = (count_q != 4'd0) && (fifo_q[rd_ptr_q].cd == CD_W'(1));

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem[line_idx] <= proc2Imem_data;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (fifo_q[i].cd != '0) begin
                fifo_q[i].cd <= fifo_q[i].cd - CD_W'(1);
            end
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= '{tag: next_tag_q, data: rd_data, cd: CD_W'(LATENCY - 1)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 4'd0;
            next_tag_q <= 4'd1;
            tag_q      <= 4'd0;
            data_q     <= 64'd0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                next_tag_q <= (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                tag_q    <= fifo_q[rd_ptr_q].tag;
                data_q   <= fifo_q[rd_ptr_q].data;
            end else if (bypass) begin
                tag_q  <= next_tag_q;
                data_q <= rd_data;
            end else begin
                tag_q <= 4'd0;
            end
        end
    end

    assign Imem2proc_tag  = tag_q;
    assign Imem2proc_data = data_q;

endmodule
